// File: rtl/syn_lb_modport_slave.sv
// Local-bus register slave: ID, live STATUS and a bank of R/W CFG registers behind single-cycle strobes.
// Latency: 1 cycle from strobe to wr_valid/rd_valid/err_o; CFG writes land on cfg_o after the same edge.
// Backpressure: none; a strobe may be accepted every cycle and responses are never stalled.
module syn_lb_modport_slave #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 12,
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VAL   = 32'h5359_4E00
) (
    input  logic                           clk_ir,
    input  logic                           rst_il,
    input  logic                           rd_en,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic                           wr_valid,
    output logic                           rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    input  logic [DATA_W-1:0]              status_i,
    output logic [(NUM_REGS-2)*DATA_W-1:0] cfg_o,
    output logic                           err_o
);

    localparam int                NCFG    = NUM_REGS - 2;
    localparam logic [ADDR_W-1:0] A_ID    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CFG0  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_LIMIT = ADDR_W'(NUM_REGS);
    localparam logic [DATA_W-1:0] ID_DAT  = DATA_W'(ID_VAL);

    logic [DATA_W-1:0] cfg_q [NCFG];
    logic              in_map;
    logic              cfg_hit;
    logic              rd_only;
    logic              acc_err;
    logic [DATA_W-1:0] rd_mux;

    // Address decode and read mux are purely combinational off the strobe cycle.
    always_comb begin
        in_map  = (addr < A_LIMIT);
        cfg_hit = in_map && (addr >= A_CFG0);
        rd_only = rd_en && !wr_en;
        acc_err = (wr_en && !cfg_hit) || (wr_en && rd_en) || (rd_only && !in_map);
        rd_mux  = '0;
        if (addr == A_ID) begin
            rd_mux = ID_DAT;
        end else if (addr == A_STAT) begin
            rd_mux = status_i;
        end else begin
            for (int k = 0; k < NCFG; k++) begin
                if (addr == ADDR_W'(k + 2)) begin
                    rd_mux = cfg_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            wr_valid <= 1'b0;
            rd_valid <= 1'b0;
            err_o    <= 1'b0;
            rd_data  <= '0;
            for (int k = 0; k < NCFG; k++) begin
                cfg_q[k] <= '0;
            end
        end else begin
            wr_valid <= wr_en;
            rd_valid <= rd_only;
            err_o    <= acc_err;
            // A colliding read is dropped, so rd_data only moves on a clean read.
            if (rd_only) begin
                rd_data <= rd_mux;
            end
            for (int k = 0; k < NCFG; k++) begin
                if (wr_en && cfg_hit && (addr == ADDR_W'(k + 2))) begin
                    cfg_q[k] <= wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg_out
        assign cfg_o[g*DATA_W +: DATA_W] = cfg_q[g];
    end

endmodule

// File: tb/tb_syn_lb_modport_slave.sv
// Scoreboard bench for syn_lb_modport_slave: per-cycle expected responses queued at drive time.
module tb_syn_lb_modport_slave;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int NR  = 16;
    localparam int CW  = (NR - 2) * DW;
    localparam logic [31:0] ID = 32'h5359_4E00;

    logic          clk_ir = 1'b0;
    logic          rst_il = 1'b1;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] status_i = '0;
    logic          wr_valid;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] cfg_o;
    logic          err_o;

    syn_lb_modport_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ID_VAL(ID)) dut (
        .clk_ir   (clk_ir),
        .rst_il   (rst_il),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .status_i (status_i),
        .cfg_o    (cfg_o),
        .err_o    (err_o)
    );

    always #5 clk_ir = ~clk_ir;

    typedef struct {
        logic          wv;
        logic          rv;
        logic          err;
        logic [DW-1:0] rd;
        logic [CW-1:0] cfg;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_cfg [NR];
    logic [DW-1:0] m_rd = '0;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus and queue what the slave must show after the next edge.
    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] st);
        exp_t e;
        int   ai;
        @(negedge clk_ir);
        rst_il = rst; rd_en = rd; wr_en = wr; addr = a; wr_data = d; status_i = st;
        ai = int'(a);
        if (rst) begin
            for (int k = 0; k < NR; k++) m_cfg[k] = '0;
            m_rd  = '0;
            e.wv  = 1'b0;
            e.rv  = 1'b0;
            e.err = 1'b0;
        end else begin
            e.wv  = wr;
            e.rv  = rd && !wr;
            e.err = wr ? ((ai < 2) || (ai >= NR) || rd) : (rd && (ai >= NR));
            if (rd && !wr) begin
                if (ai == 0)       m_rd = ID;
                else if (ai == 1)  m_rd = st;
                else if (ai < NR)  m_rd = m_cfg[ai];
                else               m_rd = '0;
            end
            if (wr && ai >= 2 && ai < NR) m_cfg[ai] = d;
        end
        e.rd = m_rd;
        for (int k = 0; k < NR - 2; k++) e.cfg[k*DW +: DW] = m_cfg[k+2];
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, status_i);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_ir);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_valid", CW'(wr_valid), CW'(e.wv));
                chk("rd_valid", CW'(rd_valid), CW'(e.rv));
                chk("err_o",    CW'(err_o),    CW'(e.err));
                chk("rd_data",  CW'(rd_data),  CW'(e.rd));
                chk("cfg_o",    cfg_o,         e.cfg);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int k = 0; k < NR; k++) m_cfg[k] = '0;
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        idle(1);
        // ID and unwritten CFG
        drive(1'b0, 1'b1, 1'b0, 12'd0, '0, '0);
        drive(1'b0, 1'b1, 1'b0, 12'd5, '0, '0);
        // write then immediate read-back
        drive(1'b0, 1'b0, 1'b1, 12'd2, 32'hA5A5_0001, '0);
        drive(1'b0, 1'b1, 1'b0, 12'd2, '0, '0);
        // status reads around a rejected write
        drive(1'b0, 1'b1, 1'b0, 12'd1, '0, 32'h0000_00F0);
        drive(1'b0, 1'b0, 1'b1, 12'd1, 32'hFFFF_FFFF, 32'h0000_00F0);
        drive(1'b0, 1'b1, 1'b0, 12'd1, '0, 32'h0000_0A0B);
        drive(1'b0, 1'b0, 1'b1, 12'd0, 32'hDEAD_BEEF, 32'h0000_0A0B);
        // out of range
        drive(1'b0, 1'b1, 1'b0, 12'd16, '0, '0);
        drive(1'b0, 1'b0, 1'b1, 12'd4095, 32'h7777_7777, '0);
        drive(1'b0, 1'b0, 1'b1, 12'd15, 32'h0F0F_0F0F, '0);
        drive(1'b0, 1'b1, 1'b0, 12'd15, '0, '0);
        // collision: write wins, read dropped
        drive(1'b0, 1'b1, 1'b1, 12'd3, 32'h0000_1234, '0);
        drive(1'b0, 1'b1, 1'b0, 12'd3, '0, '0);
        idle(1);
        // reset during a read strobe
        drive(1'b0, 1'b0, 1'b1, 12'd7, 32'hCAFE_0007, '0);
        drive(1'b0, 1'b1, 1'b0, 12'd7, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 12'd7, '0, '0);
        drive(1'b0, 1'b1, 1'b0, 12'd7, '0, '0);
        idle(1);
        // mixed random traffic
        for (int i = 0; i < 300; i++) begin
            logic          r, w, rs;
            logic [AW-1:0] a;
            r  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 49) == 0);
            a  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, NR + 2));
            drive(rs, r, w, a, $urandom, $urandom);
        end
        idle(2);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_ir);
        #2;
        if (sb.size() != 0) chk("sb_drain", CW'(sb.size()), CW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_lb_modport_slave.md
# syn_lb_modport_slave

Local-bus register slave that terminates the `slave` side of the internal host local bus (rd_en/wr_en/addr/wr_data in, wr_valid/rd_valid/rd_data out). It decodes single-cycle read and write strobes into a small register file: an ID register, a read-only status register and a bank of read/write configuration registers. The configuration registers drive the surrounding datapath. It sits between the host bridge (bus master) and a functional block.

## Interface
- DATA_W, 32, bus data width
- ADDR_W, 12, bus address width (word addresses)
- NUM_REGS, 16, decoded register count; valid addresses are 0..NUM_REGS-1, NUM_REGS ≥ 3
- ID_VAL, 32'h5359_4E00, constant returned at address 0 (truncated/zero-extended to DATA_W)

Ports:
- clk_ir  in  1  sole clock; all logic on the rising edge
- rst_il  in  1  reset, synchronous, active-high
- rd_en  in  1  read strobe, one cycle per access
- wr_en  in  1  write strobe, one cycle per access
- addr  in  ADDR_W  access address, qualified by rd_en/wr_en
- wr_data  in  DATA_W  write data, qualified by wr_en
- wr_valid  out  1  write acknowledge pulse
- rd_valid  out  1  read-data-valid pulse
- rd_data  out  DATA_W  read data, valid when rd_valid=1
- status_i  in  DATA_W  live status word, readable at address 1
- cfg_o  out  (NUM_REGS-2)*DATA_W  flattened config registers; slice k = register at address k+2
- err_o  out  1  one-cycle error pulse

## Operation
- Address map: 0 = ID (RO, ID_VAL); 1 = STATUS (RO, status_i sampled on the rd_en cycle); 2..NUM_REGS-1 = CFG (RW, reset 0).
- Write (wr_en=1, rd_en=0): if addr in 2..NUM_REGS-1, the register loads wr_data at that edge. Writes to 0, 1 or addr ≥ NUM_REGS change nothing and raise err_o. wr_valid is pulsed for every write, valid or not.
- Read (rd_en=1, wr_en=0): rd_data gets the addressed value and rd_valid pulses. addr ≥ NUM_REGS returns 0 and raises err_o.
- rd_en and wr_en together: the write is performed as above, the read is dropped (no rd_valid, rd_data unchanged), and err_o pulses.
- cfg_o is driven directly from the register flops, so a write is visible on cfg_o one cycle after wr_en.
- rd_data holds its last value between reads.
- No wait states and no backpressure. A strobe may be presented on every cycle.

## Timing
- Reset (rst_il=1 at an edge):
  - wr_valid=0, rd_valid=0, err_o=0, rd_data=0
  - all CFG registers = 0, so cfg_o=0
  - any strobe present in the same cycle is ignored
- Reset asserted with an access in flight: the pending wr_valid/rd_valid is cancelled, with nothing emitted on the following cycle.
- Write latency:
  - wr_en sampled at edge N
  - register updated at edge N, so cfg_o reflects it after edge N
  - wr_valid high for exactly the cycle after edge N
- Read latency:
  - rd_en sampled at edge N
  - rd_valid=1 and rd_data are presented for the cycle after edge N (1-cycle latency)
  - rd_valid is a single-cycle pulse per strobe
- err_o is aligned with the corresponding wr_valid/rd_valid cycle and lasts one cycle.
- Back-to-back:
  - a read of address A on the cycle after a write to A returns the new data
  - consecutive read strobes give consecutive rd_valid pulses

## Test plan
- Reset then read addr 0 -> one cycle later rd_valid=1, rd_data=32'h5359_4E00, err_o=0. Read addr 5 -> 0.
- Write 32'hA5A5_0001 to addr 2, then read addr 2 on the next cycle -> wr_valid pulses one cycle after wr_en. cfg_o[31:0]=32'hA5A5_0001. Read returns 32'hA5A5_0001.
- status_i=32'h0000_00F0, read addr 1 -> rd_data=32'h0000_00F0. Write 32'hFFFF_FFFF to addr 1 -> wr_valid=1, err_o=1, a subsequent read still tracks status_i.
- Read addr 16 and write addr 4095 (NUM_REGS=16) -> read returns 0 with err_o=1. Write gives wr_valid=1, err_o=1 and no change to cfg_o.
- Same cycle rd_en=wr_en=1, addr 3, wr_data=32'h1234 -> register 3 = 32'h1234, wr_valid=1, err_o=1, no rd_valid, rd_data unchanged.
- Write addr 7, then assert rst_il mid-sequence during a read strobe -> no rd_valid follows, cfg_o returns to 0, and a read of addr 7 after reset returns 0.
